title_blitter: RTL and testbench
================================

// Module: title_blitter
// PURPOSE
//  Sequential consumer of the flat title bitmap built by the title generator (TITLE_WIDTH*TITLE_HEIGHT bits).
//  On start it captures the bitmap and walks it row-major, one cell per cycle.
//  Each visible cell becomes a single-cell write request (x,y,data) over a valid/ready port into the board/frame store.
//  Sits between the title generator and the board RAM writer in the attract/title screen path.
// PARAMETERS
//  TITLE_WIDTH   28  bitmap columns; bit index = row*TITLE_WIDTH + col
//  TITLE_HEIGHT  6   bitmap rows
//  BOARD_W       32  destination columns; XW = $clog2(BOARD_W)
//  BOARD_H       24  destination rows; YW = $clog2(BOARD_H)
// PORTS
//  clk       in   1                          system clock, rising edge
//  reset_n   in   1                          asynchronous active-low reset
//  title     in   TITLE_WIDTH*TITLE_HEIGHT   bitmap, sampled only on accepted start
//  x_off     in   XW                         column offset, sampled on accepted start
//  y_off     in   YW                         row offset, sampled on accepted start
//  start     in   1                          begin blit; accepted only in IDLE
//  wr_ready  in   1                          sink can take a write this cycle
//  wr_valid  out  1                          write request present
//  wr_x      out  XW                         dest column = x_off + col
//  wr_y      out  YW                         dest row = y_off + row
//  wr_data   out  1                          cell value (title bit)
//  busy      out  1                          high in SCAN
//  done      out  1                          one-cycle pulse after final cell
// BEHAVIOUR
//  Reset: all outputs 0; state=IDLE; row/col counters 0; captured bitmap 0.
//  Reset mid-blit aborts immediately. No write completes after reset_n falls.
//  FSM: IDLE -(start)-> SCAN -(last cell retired)-> DONE -(1 cycle)-> IDLE.
//  Accepted start latches title, x_off and y_off, clears row/col, and enters SCAN on the next edge.
//  start in SCAN or DONE is ignored; no queuing.
//  SCAN, per cycle, cell (row,col):
//   - sum_x = x_off + col and sum_y = y_off + row are computed at XW+1 / YW+1 bits.
//   - The cell is visible iff sum_x < BOARD_W and sum_y < BOARD_H.
//   - Visible: wr_valid=1, wr_x/wr_y/wr_data driven combinationally from the counters and the captured bitmap.
//   - A visible cell retires on wr_valid && wr_ready. While wr_ready=0, all payload holds stable and counters freeze.
//   - Invisible (clipped) cell: wr_valid=0; it retires unconditionally that cycle.
//   - Retire: col++; at col==TITLE_WIDTH-1, col=0 and row++.
//   - Retiring (TITLE_HEIGHT-1, TITLE_WIDTH-1) moves to DONE.
//  DONE: done=1 and busy=0 for exactly one cycle; wr_valid=0.
//  Latency: start accepted at edge N -> first wr_valid in cycle N+1 (if visible).
//   With wr_ready held high and no clipping, W*H back-to-back transfers, then done one cycle after the last.
//  wr_valid never drops without a handshake once raised for a visible cell. Payload never changes while valid && !ready.
//  Outputs other than the wr_* payload are registered.
// CONFIGURATION
//  TITLE_SKIP_ZERO_EN defined:
//   - Cells whose bit is 0 are treated as invisible (wr_valid=0, retire in 1 cycle). Only set pixels are written.
//   - wr_data is always 1 when wr_valid=1.
//  TITLE_SKIP_ZERO_EN undefined:
//   - Every in-bounds cell is written, including 0s, so the title region is fully overwritten.
// TESTING
//  1) title=0 except bit 29 (row1,col1), x_off=2, y_off=3, ready=1, no SKIP
//     -> 168 transfers; the one with wr_data=1 has (x=3,y=4); done pulses once in the cycle after transfer 168.
//  2) Same stimulus with TITLE_SKIP_ZERO_EN
//     -> exactly 1 transfer (3,4,1); done pulses 168 cycles after the first SCAN cycle.
//  3) wr_ready low for 5 cycles on transfer 10
//     -> wr_valid held high and wr_x/wr_y/wr_data constant for all 5 cycles; transfer count is still 168.
//  4) x_off=BOARD_W-4, y_off=0
//     -> only cols 0..3 of each row transfer (24 writes); wr_x max = BOARD_W-1; done pulses.
//  5) start re-asserted during SCAN, and title changed mid-scan
//     -> ignored; output data matches the bitmap captured at the original start.
//  6) reset_n low for 1 cycle mid-SCAN
//     -> wr_valid, busy and done go 0 asynchronously; state=IDLE; a new start rescans from (0,0).

Source files
------------

// File: rtl/title_blitter.sv
// title_blitter: walks a captured title bitmap row-major and issues one clipped single-cell write per cell
// Optional build macro TITLE_SKIP_ZERO_EN: only set pixels are written; zero cells are skipped like clipped ones.
module title_blitter #(
    parameter int TITLE_WIDTH  = 28,
    parameter int TITLE_HEIGHT = 6,
    parameter int BOARD_W      = 32,
    parameter int BOARD_H      = 24,
    localparam int XW = $clog2(BOARD_W),
    localparam int YW = $clog2(BOARD_H)
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic [TITLE_WIDTH*TITLE_HEIGHT-1:0] title,
    input  logic [XW-1:0]                       x_off,
    input  logic [YW-1:0]                       y_off,
    input  logic                                start,
    input  logic                                wr_ready,
    output logic                                wr_valid,
    output logic [XW-1:0]                       wr_x,
    output logic [YW-1:0]                       wr_y,
    output logic                                wr_data,
    output logic                                busy,
    output logic                                done
);
    localparam int N  = TITLE_WIDTH * TITLE_HEIGHT;
    localparam int IW = $clog2(N);
    localparam int CW = (TITLE_WIDTH > 1) ? $clog2(TITLE_WIDTH) : 1;
    localparam int RW = (TITLE_HEIGHT > 1) ? $clog2(TITLE_HEIGHT) : 1;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t        state;
    logic [N-1:0]  bitmap;
    logic [XW-1:0] x_r;
    logic [YW-1:0] y_r;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [XW:0]   sum_x;
    logic [YW:0]   sum_y;
    logic [IW-1:0] idx;
    logic          pix;
    logic          vis;
    logic          retire;
    logic          last;

    // Destination address, clipping and the current cell's bit; sums carry one extra bit so overflow clips
    always_comb begin
        sum_x  = (XW+1)'(x_r) + (XW+1)'(col);
        sum_y  = (YW+1)'(y_r) + (YW+1)'(row);
        idx    = IW'(row) * IW'(TITLE_WIDTH) + IW'(col);
        pix    = bitmap[idx];
        vis    = (state == SCAN) && (sum_x < (XW+1)'(BOARD_W)) && (sum_y < (YW+1)'(BOARD_H));
`ifdef TITLE_SKIP_ZERO_EN
        vis    = vis && pix;
`endif
        retire = (state == SCAN) && (!vis || wr_ready);
        last   = (row == RW'(TITLE_HEIGHT-1)) && (col == CW'(TITLE_WIDTH-1));
    end

    assign wr_valid = vis;
    assign wr_x     = vis ? sum_x[XW-1:0] : '0;
    assign wr_y     = vis ? sum_y[YW-1:0] : '0;
    assign wr_data  = vis & pix;

    // Blit sequencer: capture on start, step one cell per retire, pulse done after the final cell
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            bitmap <= '0;
            x_r    <= '0;
            y_r    <= '0;
            col    <= '0;
            row    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    bitmap <= title;
                    x_r    <= x_off;
                    y_r    <= y_off;
                    col    <= '0;
                    row    <= '0;
                    busy   <= 1'b1;
                    state  <= SCAN;
                end
                SCAN: if (retire) begin
                    if (last) begin
                        col   <= '0;
                        row   <= '0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else if (col == CW'(TITLE_WIDTH-1)) begin
                        col <= '0;
                        row <= row + 1'b1;
                    end else begin
                        col <= col + 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_title_blitter.sv
// tb_title_blitter: table-driven blits checked against a write-order scoreboard, plus stall, restart and reset cases
module tb_title_blitter;
    localparam int TW = 28;
    localparam int TH = 6;
    localparam int N  = TW * TH;
`ifdef TITLE_SKIP_ZERO_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    typedef struct {
        logic [N-1:0] t;
        int           xo;
        int           yo;
        int           stall_at;
        int           stall_len;
        int           mid_k;
        int           exp_n;
        int           exp_k;
        int           exp_maxx;
        string        name;
    } vec_t;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         start = 1'b0;
    logic         wr_ready = 1'b1;
    logic [N-1:0] title = '0;
    logic [4:0]   x_off = '0;
    logic [4:0]   y_off = '0;
    logic         wr_valid;
    logic [4:0]   wr_x;
    logic [4:0]   wr_y;
    logic         wr_data;
    logic         busy;
    logic         done;

    int           compared = 0;
    int           mismatched = 0;
    int           maxx;
    logic [10:0]  q[$];
    vec_t         vt[8];

    always #5 clk = ~clk;

    title_blitter dut (
        .clk(clk), .reset_n(reset_n), .title(title), .x_off(x_off), .y_off(y_off),
        .start(start), .wr_ready(wr_ready), .wr_valid(wr_valid), .wr_x(wr_x),
        .wr_y(wr_y), .wr_data(wr_data), .busy(busy), .done(done)
    );

    task automatic chk(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: actual %0d required %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [N-1:0] t, input int xo, input int yo, input int sa, input int sl,
                                input int mk_k, input int en, input int ek, input int em, input string nm);
        vec_t v;
        v.t = t; v.xo = xo; v.yo = yo; v.stall_at = sa; v.stall_len = sl; v.mid_k = mk_k;
        v.exp_n = en; v.exp_k = ek; v.exp_maxx = em; v.name = nm;
        return v;
    endfunction

    // Reference order of writes: every on-board cell row-major, zero cells dropped in skip mode
    task automatic model_push(input logic [N-1:0] t, input int xo, input int yo);
        for (int r = 0; r < TH; r++) begin
            for (int c = 0; c < TW; c++) begin
                int   sx = xo + c;
                int   sy = yo + r;
                logic b  = t[r*TW + c];
                bit   v  = (sx < 32) && (sy < 24);
                if (SKIP) v = v && b;
                if (v) q.push_back({sx[4:0], sy[4:0], b});
            end
        end
    endtask

    task automatic run_blit(input vec_t v);
        int          xfers = 0;
        int          dones = 0;
        int          done_k = -1;
        int          scnt = 0;
        int          n_exp;
        logic [10:0] hold = '0;
        logic [10:0] e;
        maxx = -1;
        q.delete();
        model_push(v.t, v.xo, v.yo);
        n_exp = (v.exp_n < 0) ? q.size() : v.exp_n;
        title = v.t; x_off = 5'(v.xo); y_off = 5'(v.yo); wr_ready = 1'b1; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int k = 1; k <= 1000; k++) begin
            wr_ready = !(v.stall_at > 0 && xfers == v.stall_at - 1 && scnt < v.stall_len);
            start = (v.mid_k > 0) && (k >= v.mid_k) && (k < v.mid_k + 6);
            title = start ? ~v.t : v.t;
            x_off = start ? ~5'(v.xo) : 5'(v.xo);
            @(negedge clk);
            if (k == 1) chk({v.name, " busy_in_scan"}, int'(busy), 1);
            if (!wr_ready) begin
                chk({v.name, " stall_valid"}, int'(wr_valid), 1);
                if (scnt > 0) chk({v.name, " stall_payload"}, int'({wr_x, wr_y, wr_data}), int'(hold));
                hold = {wr_x, wr_y, wr_data};
                scnt++;
            end else if (wr_valid) begin
                e = (q.size() > 0) ? q.pop_front() : 11'h7ff;
                chk({v.name, " write"}, int'({wr_x, wr_y, wr_data}), int'(e));
                if (int'(wr_x) > maxx) maxx = int'(wr_x);
                xfers++;
            end
            if (done) begin
                dones++;
                if (done_k < 0) begin
                    done_k = k;
                    chk({v.name, " busy_at_done"}, int'(busy), 0);
                    chk({v.name, " valid_at_done"}, int'(wr_valid), 0);
                end
            end
            if (done_k >= 0 && k >= done_k + 2) break;
            @(posedge clk); #1;
        end
        start = 1'b0;
        wr_ready = 1'b1;
        chk({v.name, " transfers"}, xfers, n_exp);
        chk({v.name, " done_pulses"}, dones, 1);
        chk({v.name, " done_cycle"}, done_k, v.exp_k);
        chk({v.name, " leftover"}, q.size(), 0);
        chk({v.name, " idle_after"}, int'(busy), 0);
        if (v.exp_maxx >= 0) chk({v.name, " max_x"}, maxx, v.exp_maxx);
    endtask

    initial begin
        logic [N-1:0] one29;
        logic [N-1:0] ones;
        logic [191:0] r1;
        logic [191:0] r2;
        one29 = '0;
        one29[29] = 1'b1;
        ones = '1;
        r1 = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        r2 = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        vt[0] = mk(one29, 2, 3, 0, 0, 0, SKIP ? 1 : 168, 169, SKIP ? 3 : 29, "single_pixel");
        vt[1] = mk(one29, 2, 3, 10, 5, 0, SKIP ? 1 : 168, SKIP ? 169 : 174, -1, "ready_stall");
        vt[2] = mk(ones, 28, 0, 0, 0, 0, 24, 169, 31, "x_clip");
        vt[3] = mk(ones, 0, 20, 0, 0, 0, 112, 169, 27, "y_clip");
        vt[4] = mk(ones, 31, 23, 0, 0, 0, 1, 169, 31, "corner");
        vt[5] = mk('0, 0, 0, 0, 0, 0, SKIP ? 0 : 168, 169, SKIP ? -1 : 27, "all_zero");
        vt[6] = mk(r1[N-1:0], 4, 10, 0, 0, 0, -1, 169, -1, "random");
        vt[7] = mk(r2[N-1:0], 0, 0, 0, 0, 20, -1, 169, -1, "mid_start");

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset wr_valid", int'(wr_valid), 0);
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        chk("reset wr_x", int'(wr_x), 0);
        chk("reset wr_y", int'(wr_y), 0);
        chk("reset wr_data", int'(wr_data), 0);
        reset_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) run_blit(vt[i]);

        title = ones; x_off = '0; y_off = '0; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (30) @(posedge clk);
        #1 chk("pre_abort busy", int'(busy), 1);
        #1 reset_n = 1'b0;
        #1;
        chk("abort wr_valid", int'(wr_valid), 0);
        chk("abort busy", int'(busy), 0);
        chk("abort done", int'(done), 0);
        @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        @(negedge clk);
        chk("post_abort idle busy", int'(busy), 0);
        chk("post_abort idle valid", int'(wr_valid), 0);
        run_blit(vt[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
